apb_accum_mc: RTL and testbench



---
 rtl/apb_accum_mc.sv | 170 +++++++++++++++++
 tb/tb_apb_accum_mc.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_accum_mc.sv
// Multi-channel APB3 accumulator slave.
// Each channel folds DATA into RESULT with OR/AND/XOR/ADD on START.
module apb_accum_mc #(
  parameter int NUM_CH      = 4,
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 8,
  parameter int WAIT_STATES = 0
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [ADDR_W-1:0] PADDR,
  input  logic [DATA_W-1:0] PWDATA,
  output logic [DATA_W-1:0] PRDATA,
  output logic              PREADY,
  output logic              PSLVERR,
  output logic [NUM_CH-1:0] done_o
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  localparam logic [1:0] M_OR  = 2'b00;
  localparam logic [1:0] M_AND = 2'b01;
  localparam logic [1:0] M_XOR = 2'b10;
  localparam logic [1:0] M_ADD = 2'b11;

  state_t state, state_nx;
  logic [2:0] cnt;
  logic ready;

  logic [3:0] ch;
  logic [1:0] off;
  logic hi_bad, bad, err, wr;
  logic [DATA_W-1:0] rdata;

  logic [DATA_W-1:0] data_q [NUM_CH];
  logic [DATA_W-1:0] res_q  [NUM_CH];
  logic [1:0]        mode_q [NUM_CH];
  logic [DATA_W:0]   nxt    [NUM_CH];
  logic [NUM_CH-1:0] pend_q, ovf_q, done_q;
  logic [NUM_CH-1:0] wsel, w1c, ovf_set;

  function automatic logic [DATA_W:0] op(
    input logic [1:0]        m,
    input logic [DATA_W-1:0] a,
    input logic [DATA_W-1:0] b
  );
    unique case (m)
      M_OR:    op = {1'b0, a | b};
      M_AND:   op = {1'b0, a & b};
      M_XOR:   op = {1'b0, a ^ b};
      default: op = {1'b0, a} + {1'b0, b};
    endcase
  endfunction

  // Transfer FSM
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      if (state == SETUP)
        cnt <= 3'(WAIT_STATES);
      else if (state == ACCESS && cnt != 3'd0)
        cnt <= cnt - 3'd1;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:
        if (PSEL && !PENABLE) state_nx = SETUP;
      SETUP:
        state_nx = ACCESS;
      ACCESS:
        if (ready)
          state_nx = (PSEL && !PENABLE) ? SETUP : IDLE;
        else if (!PSEL)
          state_nx = IDLE;
      default:
        state_nx = IDLE;
    endcase
  end

  always_comb begin
    ready = (state == ACCESS) && PSEL && PENABLE
         && (cnt == 3'd0) && !PRESET;
    PREADY  = ready;
    PSLVERR = ready && err;
    PRDATA  = (ready && !err) ? rdata : '0;
  end

  // Address decode
  assign ch  = PADDR[7:4];
  assign off = PADDR[3:2];

  generate
    if (ADDR_W > 8) begin : g_hi
      assign hi_bad = |PADDR[ADDR_W-1:8];
    end else begin : g_nohi
      assign hi_bad = 1'b0;
    end
  endgenerate

  assign bad = (int'(ch) >= NUM_CH) || (PADDR[1:0] != 2'b00) || hi_bad;
  assign err = bad || (PWRITE && off == 2'd2);
  assign wr  = ready && PWRITE && !err;

  always_comb begin
    rdata = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (ch == 4'(c)) begin
        unique case (off)
          2'd0: rdata = data_q[c];
          2'd1: rdata = DATA_W'({mode_q[c], 1'b0});
          2'd2: rdata = res_q[c];
          default: rdata = DATA_W'({ovf_q[c], pend_q[c]});
        endcase
      end
    end
  end

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      wsel[c]    = wr && (ch == 4'(c));
      w1c[c]     = wsel[c] && off == 2'd3 && PWDATA[1];
      nxt[c]     = op(mode_q[c], res_q[c], data_q[c]);
      ovf_set[c] = pend_q[c] && mode_q[c] == M_ADD && nxt[c][DATA_W];
    end
  end

  // Channel state; a pending start commits on the edge after it is written
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      for (int c = 0; c < NUM_CH; c++) begin
        data_q[c] <= '0;
        res_q[c]  <= '0;
        mode_q[c] <= M_OR;
      end
      pend_q <= '0;
      ovf_q  <= '0;
      done_q <= '0;
    end else begin
      done_q <= pend_q;
      ovf_q  <= (ovf_q & ~w1c) | ovf_set;
      for (int c = 0; c < NUM_CH; c++) begin
        if (pend_q[c]) begin
          res_q[c]  <= nxt[c][DATA_W-1:0];
          pend_q[c] <= 1'b0;
        end
        if (wsel[c] && off == 2'd0)
          data_q[c] <= PWDATA;
        if (wsel[c] && off == 2'd1) begin
          mode_q[c] <= PWDATA[2:1];
          if (PWDATA[3])
            res_q[c] <= (PWDATA[2:1] == M_AND) ? '1 : '0;
          else if (PWDATA[0])
            pend_q[c] <= 1'b1;
        end
      end
    end
  end

  assign done_o = done_q;

endmodule

// File: tb/tb_apb_accum_mc.sv
// Bench for apb_accum_mc: directed table, random traffic vs model,
// and reset abort of a pending commit.
module tb_apb_accum_mc;

  localparam int NCH = 4;
  localparam int DW  = 32;
  localparam int AW  = 8;
  localparam int WS  = 2;

  logic          PCLK = 1'b0;
  logic          PRESET;
  logic          PSEL, PENABLE, PWRITE;
  logic [AW-1:0] PADDR;
  logic [DW-1:0] PWDATA, PRDATA;
  logic          PREADY, PSLVERR;
  logic [NCH-1:0] done_o;

  apb_accum_mc #(
    .NUM_CH(NCH), .DATA_W(DW), .ADDR_W(AW), .WAIT_STATES(WS)
  ) dut (
    .PCLK(PCLK), .PRESET(PRESET), .PSEL(PSEL), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA),
    .PREADY(PREADY), .PSLVERR(PSLVERR), .done_o(done_o)
  );

  always #5 PCLK = ~PCLK;

  int tests = 0;
  int fails = 0;
  int early = 0;
  int badwait = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // done pulse monitor
  int dcnt[NCH] = '{default: 0};
  int dwide = 0;
  logic [NCH-1:0] dprev = '0;
  always @(negedge PCLK) begin
    if (PRESET) dprev = '0;
    else begin
      for (int c = 0; c < NCH; c++)
        if (done_o[c]) begin
          dcnt[c]++;
          if (dprev[c]) dwide++;
        end
      dprev = done_o;
    end
  end

  // reference model
  logic [31:0] m_data[NCH];
  logic [31:0] m_res[NCH];
  logic [1:0]  m_mode[NCH];
  bit          m_ovf[NCH];
  int          m_done[NCH];

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_data[c] = 0; m_res[c] = 0; m_mode[c] = 0; m_ovf[c] = 0;
    end
  endtask

  task automatic predict(input bit wr, input logic [7:0] a,
                         input logic [31:0] wd,
                         output logic [31:0] rd, output bit e);
    int c, o;
    longint unsigned s;
    c = int'(a[7:4]);
    o = int'(a[3:2]);
    e = (c >= NCH) || (a[1:0] != 2'b00) || (wr && o == 2);
    rd = 0;
    if (e) return;
    if (!wr) begin
      case (o)
        0: rd = m_data[c];
        1: rd = 32'(m_mode[c]) * 2;
        2: rd = m_res[c];
        default: rd = m_ovf[c] ? 32'h2 : 32'h0;
      endcase
    end else begin
      case (o)
        0: m_data[c] = wd;
        1: begin
          m_mode[c] = wd[2:1];
          if (wd[3]) m_res[c] = (m_mode[c] == 2'd1) ? 32'hFFFF_FFFF : 0;
          else if (wd[0]) begin
            m_done[c]++;
            case (m_mode[c])
              2'd0: m_res[c] = m_res[c] | m_data[c];
              2'd1: m_res[c] = m_res[c] & m_data[c];
              2'd2: m_res[c] = m_res[c] ^ m_data[c];
              default: begin
                s = 64'(m_res[c]) + 64'(m_data[c]);
                if ((s >> 32) != 0) m_ovf[c] = 1;
                m_res[c] = s[31:0];
              end
            endcase
          end
        end
        default: if (wd[1]) m_ovf[c] = 0;
      endcase
    end
  endtask

  task automatic apb(input bit wr, input logic [7:0] a,
                     input logic [31:0] wd, input bit rst_after,
                     output logic [31:0] rd, output logic e);
    int w;
    w = 0;
    @(posedge PCLK); #1;
    PSEL = 1; PENABLE = 0; PWRITE = wr; PADDR = a; PWDATA = wd;
    @(posedge PCLK); #1;
    PENABLE = 1;
    #1;
    while (!PREADY && w < 40) begin
      if (PRDATA !== '0 || PSLVERR !== 1'b0) early++;
      w++;
      @(posedge PCLK); #2;
    end
    if (!PREADY) begin
      tests++; fails++;
      $display("FAIL pready_timeout: got 0 expected 1 addr %h", a);
    end
    rd = PRDATA;
    e  = PSLVERR;
    if (w != WS + 1) badwait++;
    @(posedge PCLK); #1;
    PSEL = 0; PENABLE = 0;
    if (rst_after) PRESET = 1;
  endtask

  typedef struct {
    bit          wr;
    logic [7:0]  addr;
    logic [31:0] wd;
    logic [31:0] rd;
    bit          err;
  } vec_t;

  vec_t tbl[$];

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd, exp_rd;
    logic e;
    bit exp_e;
    int d3;

    PRESET = 1; PSEL = 0; PENABLE = 0; PWRITE = 0;
    PADDR = 0; PWDATA = 0;
    for (int c = 0; c < NCH; c++) m_done[c] = 0;
    model_reset();
    repeat (3) @(posedge PCLK);
    #1 PRESET = 0;
    @(negedge PCLK);
    check("rst_pready", 32'(PREADY), 0);
    check("rst_prdata", PRDATA, 0);
    check("rst_pslverr", 32'(PSLVERR), 0);
    check("rst_done", 32'(done_o), 0);

    // reset reads
    tbl.push_back('{0, 8'h00, 0, 0, 0});
    tbl.push_back('{0, 8'h04, 0, 0, 0});
    tbl.push_back('{0, 8'h08, 0, 0, 0});
    tbl.push_back('{0, 8'h0C, 0, 0, 0});
    // ch0 OR
    tbl.push_back('{1, 8'h00, 32'h0C, 0, 0});
    tbl.push_back('{1, 8'h04, 32'h1, 0, 0});
    tbl.push_back('{1, 8'h00, 32'hB0, 0, 0});
    tbl.push_back('{1, 8'h04, 32'h1, 0, 0});
    tbl.push_back('{1, 8'h00, 32'hA00, 0, 0});
    tbl.push_back('{1, 8'h04, 32'h1, 0, 0});
    tbl.push_back('{0, 8'h08, 0, 32'hABC, 0});
    tbl.push_back('{0, 8'h0C, 0, 0, 0});
    // ch1 AND with clear to identity
    tbl.push_back('{1, 8'h14, 32'hA, 0, 0});
    tbl.push_back('{0, 8'h18, 0, 32'hFFFF_FFFF, 0});
    tbl.push_back('{0, 8'h14, 0, 32'h2, 0});
    tbl.push_back('{1, 8'h10, 32'h0F0F_0F0F, 0, 0});
    tbl.push_back('{1, 8'h14, 32'h3, 0, 0});
    tbl.push_back('{0, 8'h18, 0, 32'h0F0F_0F0F, 0});
    tbl.push_back('{0, 8'h08, 0, 32'hABC, 0});
    // ch2 ADD with carry
    tbl.push_back('{1, 8'h24, 32'hE, 0, 0});
    tbl.push_back('{1, 8'h20, 32'hFFFF_FFFF, 0, 0});
    tbl.push_back('{1, 8'h24, 32'h7, 0, 0});
    tbl.push_back('{1, 8'h20, 32'h2, 0, 0});
    tbl.push_back('{1, 8'h24, 32'h7, 0, 0});
    tbl.push_back('{0, 8'h28, 0, 32'h1, 0});
    tbl.push_back('{0, 8'h2C, 0, 32'h2, 0});
    tbl.push_back('{1, 8'h2C, 32'h2, 0, 0});
    tbl.push_back('{0, 8'h2C, 0, 32'h0, 0});
    tbl.push_back('{1, 8'h24, 32'h0, 0, 0});
    tbl.push_back('{0, 8'h28, 0, 32'h1, 0});
    // errors
    tbl.push_back('{1, 8'h08, 32'h1234, 0, 1});
    tbl.push_back('{0, 8'h08, 0, 32'hABC, 0});
    tbl.push_back('{1, 8'h40, 32'h5, 0, 1});
    tbl.push_back('{0, 8'h40, 0, 0, 1});
    tbl.push_back('{0, 8'h02, 0, 0, 1});
    tbl.push_back('{0, 8'hF0, 0, 0, 1});
    tbl.push_back('{0, 8'h00, 0, 32'hA00, 0});
    // start+clear: clear wins
    tbl.push_back('{1, 8'h04, 32'h9, 0, 0});
    tbl.push_back('{0, 8'h08, 0, 0, 0});
    tbl.push_back('{0, 8'h0C, 0, 0, 0});

    foreach (tbl[i]) begin
      predict(tbl[i].wr, tbl[i].addr, tbl[i].wd, exp_rd, exp_e);
      apb(tbl[i].wr, tbl[i].addr, tbl[i].wd, 0, rd, e);
      check($sformatf("tbl%0d_err", i), 32'(e), 32'(tbl[i].err));
      if (!tbl[i].wr)
        check($sformatf("tbl%0d_rd", i), rd, tbl[i].rd);
    end
    repeat (2) @(posedge PCLK);
    #1;
    check("done_ch0", dcnt[0], 3);
    check("done_ch1", dcnt[1], 1);
    check("done_ch2", dcnt[2], 2);

    // random traffic against the model
    for (int n = 0; n < 300; n++) begin
      bit wr;
      logic [7:0] a;
      logic [31:0] wd;
      wr = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 9) == 0) a = 8'($urandom);
      else a = {4'($urandom_range(0, NCH - 1)), 2'($urandom), 2'b00};
      case ($urandom_range(0, 2))
        0: wd = $urandom;
        1: wd = 32'hFFFF_FF00 | 32'($urandom_range(0, 255));
        default: wd = 32'($urandom_range(0, 15));
      endcase
      if (a[3:2] == 2'd1 && $urandom_range(0, 3) != 0) wd[3] = 1'b0;
      predict(wr, a, wd, exp_rd, exp_e);
      apb(wr, a, wd, 0, rd, e);
      check("rnd_err", 32'(e), 32'(exp_e));
      if (!wr) check("rnd_rd", rd, exp_rd);
    end
    repeat (2) @(posedge PCLK);
    #1;
    for (int c = 0; c < NCH; c++)
      check($sformatf("rnd_done%0d", c), dcnt[c], m_done[c]);

    // reset between start completion and commit
    apb(1, 8'h30, 32'h55, 0, rd, e);
    apb(1, 8'h34, 32'h5, 0, rd, e);
    apb(1, 8'h30, 32'h0F, 0, rd, e);
    @(posedge PCLK); #1;
    d3 = dcnt[3];
    apb(1, 8'h34, 32'h5, 1, rd, e);
    repeat (2) @(posedge PCLK);
    #1 PRESET = 0;
    model_reset();
    @(negedge PCLK);
    check("abort_done_o", 32'(done_o), 0);
    apb(0, 8'h38, 0, 0, rd, e);
    check("abort_result", rd, 0);
    apb(0, 8'h34, 0, 0, rd, e);
    check("abort_mode", rd, 0);
    apb(0, 8'h3C, 0, 0, rd, e);
    check("abort_status", rd, 0);
    check("abort_done_cnt", dcnt[3], d3);

    check("done_width", dwide, 0);
    check("prdata_while_waiting", early, 0);
    check("wait_cycles", badwait, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
